// File: rtl/phase_sequencer.sv
// phase_sequencer: one-hot instruction phase generator with run/step/pause/halt control,
// a memory-wait stall on WAIT_PHASE and a retired-instruction counter.
// Optional stall watchdog enabled by defining PHASE_SEQ_WDOG_EN.
module phase_sequencer #(
  parameter int NPHASE     = 5,
  parameter int WAIT_PHASE = 1,
  parameter int CNT_W      = 32,
  parameter int WDOG_CYC   = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              run_req,
  input  logic              step_req,
  input  logic              halt_req,
  input  logic              mem_wait,
  output logic [NPHASE-1:0] phase,
  output logic              ce,
  output logic              running,
  output logic              halted,
  output logic              instr_done,
  output logic [CNT_W-1:0]  instr_cnt,
  output logic              wdog_err
);

  localparam int IW = $clog2(NPHASE);
  localparam logic [IW-1:0] LAST_IDX = IW'(NPHASE - 1);
  localparam logic [IW-1:0] WAIT_IDX = IW'(WAIT_PHASE);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_STEP = 2'd2,
    S_HALT = 2'd3
  } state_t;

  state_t           state_q;
  logic [IW-1:0]    phase_idx_q;
  logic             pause_pend_q;
  logic             running_q;
  logic             halted_q;
  logic [CNT_W-1:0] instr_cnt_q;
  logic [CNT_W-1:0] instr_cnt_d;
  logic             stall;
  logic             last_phase;
  logic             wdog_trip;

  // Datapath-facing strobes are decoded from registered state plus the live wait input.
  always_comb begin
    stall       = running_q && (phase_idx_q == WAIT_IDX) && mem_wait;
    last_phase  = (phase_idx_q == LAST_IDX);
    ce          = running_q && !stall;
    instr_done  = ce && last_phase;
    instr_cnt_d = instr_cnt_q + CNT_W'(1);
    phase       = running_q ? (NPHASE'(1) << phase_idx_q) : '0;
  end

  assign running   = running_q;
  assign halted    = halted_q;
  assign instr_cnt = instr_cnt_q;

`ifdef PHASE_SEQ_WDOG_EN
  localparam int SW = $clog2(WDOG_CYC + 1);
  localparam logic [SW-1:0] WDOG_LAST = SW'(WDOG_CYC - 1);

  logic [SW-1:0] stall_cnt_q;
  logic          wdog_err_q;

  // The trip fires on the edge that closes the WDOG_CYC-th consecutive stall cycle.
  assign wdog_trip = stall && (stall_cnt_q == WDOG_LAST);
  assign wdog_err  = wdog_err_q;

  // Count consecutive stall cycles; any non-stall cycle restarts the count.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt_q <= '0;
      wdog_err_q  <= 1'b0;
    end else begin
      stall_cnt_q <= stall ? stall_cnt_q + SW'(1) : '0;
      if (wdog_trip) begin
        wdog_err_q <= 1'b1;
      end
    end
  end
`else
  logic unused_wdog;
  assign unused_wdog = (WDOG_CYC == 0);
  assign wdog_trip   = 1'b0;
  assign wdog_err    = 1'b0;
`endif

  // Sequencer FSM: phase index, mode, pending pause, status flags and retire count.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      phase_idx_q  <= '0;
      pause_pend_q <= 1'b0;
      running_q    <= 1'b0;
      halted_q     <= 1'b0;
      instr_cnt_q  <= '0;
    end else if (wdog_trip) begin
      // Stuck memory: abandon the instruction without retiring it.
      state_q      <= S_HALT;
      phase_idx_q  <= '0;
      pause_pend_q <= 1'b0;
      running_q    <= 1'b0;
      halted_q     <= 1'b1;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (run_req) begin
            state_q   <= S_RUN;
            running_q <= 1'b1;
          end else if (step_req) begin
            state_q   <= S_STEP;
            running_q <= 1'b1;
          end
        end
        S_RUN, S_STEP: begin
          // A step request while running only arms a pause at the next boundary.
          if (state_q == S_RUN && step_req) begin
            pause_pend_q <= 1'b1;
          end
          if (ce) begin
            if (last_phase) begin
              phase_idx_q <= '0;
              instr_cnt_q <= instr_cnt_d;
              if (halt_req) begin
                state_q      <= S_HALT;
                running_q    <= 1'b0;
                halted_q     <= 1'b1;
                pause_pend_q <= 1'b0;
              end else if (state_q == S_STEP || pause_pend_q) begin
                state_q      <= S_IDLE;
                running_q    <= 1'b0;
                pause_pend_q <= 1'b0;
              end
            end else begin
              phase_idx_q <= phase_idx_q + IW'(1);
            end
          end
        end
        default: begin
          // HALT: only reset leaves this state.
          state_q <= S_HALT;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_phase_sequencer.sv
// Directed bench for phase_sequencer: a vector table for the default build plus
// hand-written sequences for long stalls and a narrow-counter wrap instance.
module tb_phase_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Default-parameter instance
  logic        rst, run_req, step_req, halt_req, mem_wait;
  logic [4:0]  phase;
  logic        ce, running, halted, instr_done, wdog_err;
  logic [31:0] instr_cnt;

  phase_sequencer dut (
    .clk(clk), .rst(rst), .run_req(run_req), .step_req(step_req),
    .halt_req(halt_req), .mem_wait(mem_wait), .phase(phase), .ce(ce),
    .running(running), .halted(halted), .instr_done(instr_done),
    .instr_cnt(instr_cnt), .wdog_err(wdog_err)
  );

  // Three-phase instance with a 4-bit counter for wrap checks
  logic        rst3, run3, step3, halt3, mw3;
  logic [2:0]  phase3;
  logic        ce3, running3, halted3, done3, wdog3;
  logic [3:0]  cnt3;

  phase_sequencer #(.NPHASE(3), .WAIT_PHASE(1), .CNT_W(4)) dut3 (
    .clk(clk), .rst(rst3), .run_req(run3), .step_req(step3),
    .halt_req(halt3), .mem_wait(mw3), .phase(phase3), .ce(ce3),
    .running(running3), .halted(halted3), .instr_done(done3),
    .instr_cnt(cnt3), .wdog_err(wdog3)
  );

  typedef struct packed {
    logic        rst, run, step, halt, mw;
    logic [4:0]  ph;
    logic        ce, rn, hl, dn;
    logic [31:0] cnt;
  } vec_t;

  vec_t vq[$];
  int   errors = 0;
  int   checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic add(input logic r, input logic ru, input logic st, input logic h,
                     input logic m, input logic [4:0] p, input logic c, input logic rn,
                     input logic hl, input logic dn, input logic [31:0] n);
    vec_t v;
    v.rst = r; v.run = ru; v.step = st; v.halt = h; v.mw = m;
    v.ph = p; v.ce = c; v.rn = rn; v.hl = hl; v.dn = dn; v.cnt = n;
    vq.push_back(v);
  endtask

  task automatic chk_main(input string tag, input logic [4:0] p, input logic c,
                          input logic rn, input logic hl, input logic dn,
                          input logic [31:0] n);
    chk({tag, ".phase"},      32'(phase),      32'(p));
    chk({tag, ".ce"},         32'(ce),         32'(c));
    chk({tag, ".running"},    32'(running),    32'(rn));
    chk({tag, ".halted"},     32'(halted),     32'(hl));
    chk({tag, ".instr_done"}, 32'(instr_done), 32'(dn));
    chk({tag, ".instr_cnt"},  instr_cnt,       n);
    chk({tag, ".wdog_err"},   32'(wdog_err),   32'(0));
  endtask

  initial begin
    // rst run step halt mw | phase ce run hlt done cnt
    // Continuous run from IDLE: 12 cycles after the request
    add(0,1,0,0,0, 5'b00000,0,0,0,0,0);
    add(0,0,0,0,0, 5'b00001,1,1,0,0,0);
    add(0,0,0,0,0, 5'b00010,1,1,0,0,0);
    add(0,0,0,0,0, 5'b00100,1,1,0,0,0);
    add(0,0,0,0,0, 5'b01000,1,1,0,0,0);
    add(0,0,0,0,0, 5'b10000,1,1,0,1,0);
    add(0,0,0,0,0, 5'b00001,1,1,0,0,1);
    add(0,0,0,0,0, 5'b00010,1,1,0,0,1);
    add(0,0,0,0,0, 5'b00100,1,1,0,0,1);
    add(0,0,0,0,0, 5'b01000,1,1,0,0,1);
    add(0,0,0,0,0, 5'b10000,1,1,0,1,1);
    add(0,0,0,0,0, 5'b00001,1,1,0,0,2);
    add(0,0,0,0,0, 5'b00010,1,1,0,0,2);
    // Pause request at phase[2]: instruction finishes, then IDLE
    add(0,0,1,0,0, 5'b00100,1,1,0,0,2);
    add(0,0,0,0,0, 5'b01000,1,1,0,0,2);
    add(0,0,0,0,0, 5'b10000,1,1,0,1,2);
    add(0,0,0,0,0, 5'b00000,0,0,0,0,3);
    add(0,0,0,0,0, 5'b00000,0,0,0,0,3);
    // Single step; run/step requests during STEP are ignored
    add(0,0,1,0,0, 5'b00000,0,0,0,0,3);
    add(0,0,0,0,0, 5'b00001,1,1,0,0,3);
    add(0,1,0,0,0, 5'b00010,1,1,0,0,3);
    add(0,0,0,0,0, 5'b00100,1,1,0,0,3);
    add(0,0,1,0,0, 5'b01000,1,1,0,0,3);
    add(0,0,0,0,0, 5'b10000,1,1,0,1,3);
    add(0,0,0,0,0, 5'b00000,0,0,0,0,4);
    // run+step together -> RUN; 3-cycle memory stall at phase[1]
    add(0,1,1,0,0, 5'b00000,0,0,0,0,4);
    add(0,0,0,0,0, 5'b00001,1,1,0,0,4);
    add(0,0,0,0,1, 5'b00010,0,1,0,0,4);
    add(0,0,0,0,1, 5'b00010,0,1,0,0,4);
    add(0,0,0,0,1, 5'b00010,0,1,0,0,4);
    add(0,0,0,0,0, 5'b00010,1,1,0,0,4);
    add(0,0,0,0,1, 5'b00100,1,1,0,0,4);
    add(0,0,0,0,0, 5'b01000,1,1,0,0,4);
    add(0,0,0,0,0, 5'b10000,1,1,0,1,4);
    // Still RUN; halt_req ignored at phase[0], honoured at the last phase
    add(0,0,0,1,0, 5'b00001,1,1,0,0,5);
    add(0,0,0,0,0, 5'b00010,1,1,0,0,5);
    add(0,0,0,0,0, 5'b00100,1,1,0,0,5);
    add(0,0,0,0,0, 5'b01000,1,1,0,0,5);
    add(0,0,0,1,0, 5'b10000,1,1,0,1,5);
    add(0,1,0,0,0, 5'b00000,0,0,1,0,6);
    add(0,0,1,0,0, 5'b00000,0,0,1,0,6);
    add(0,0,0,0,0, 5'b00000,0,0,1,0,6);
    // Reset leaves HALT; reset mid-instruction aborts without a count
    add(1,0,0,0,0, 5'b00000,0,0,1,0,6);
    add(0,1,0,0,0, 5'b00000,0,0,0,0,0);
    add(0,0,0,0,0, 5'b00001,1,1,0,0,0);
    add(1,0,0,0,0, 5'b00010,1,1,0,0,0);
    add(0,0,0,0,0, 5'b00000,0,0,0,0,0);

    rst = 1; run_req = 0; step_req = 0; halt_req = 0; mem_wait = 0;
    rst3 = 1; run3 = 0; step3 = 0; halt3 = 0; mw3 = 0;
    repeat (2) @(negedge clk);
    rst = 0; rst3 = 0;
    #1;
    chk_main("reset", 5'b00000, 0, 0, 0, 0, 0);
    chk("reset.phase3", 32'(phase3), 0);
    chk("reset.cnt3",   32'(cnt3),   0);

    for (int i = 0; i < vq.size(); i++) begin
      @(negedge clk);
      rst = vq[i].rst; run_req = vq[i].run; step_req = vq[i].step;
      halt_req = vq[i].halt; mem_wait = vq[i].mw;
      #1;
      chk_main($sformatf("vec%0d", i), vq[i].ph, vq[i].ce, vq[i].rn, vq[i].hl,
               vq[i].dn, vq[i].cnt);
    end

    // Long stall at phase[1]: watchdog behaviour depends on the build
    @(negedge clk); rst = 0; run_req = 1; step_req = 0; halt_req = 0; mem_wait = 0;
    @(negedge clk); run_req = 0;
    @(negedge clk); mem_wait = 1;
    repeat (300) @(negedge clk);
    #1;
`ifdef PHASE_SEQ_WDOG_EN
    chk("wdog.err",     32'(wdog_err), 1);
    chk("wdog.halted",  32'(halted),   1);
    chk("wdog.phase",   32'(phase),    0);
    chk("wdog.cnt",     instr_cnt,     0);
`else
    chk("stall.err",    32'(wdog_err), 0);
    chk("stall.phase",  32'(phase),    32'h2);
    chk("stall.ce",     32'(ce),       0);
    chk("stall.cnt",    instr_cnt,     0);
`endif
    mem_wait = 0;

    // Narrow instance: phase cycling and counter wrap 15 -> 0
    @(negedge clk); run3 = 1;
    @(negedge clk); run3 = 0;
    for (int k = 1; k <= 49; k++) begin
      #1;
      chk($sformatf("wrap.phase k%0d", k), 32'(phase3), 32'(3'b001 << ((k - 1) % 3)));
      chk($sformatf("wrap.cnt k%0d", k),   32'(cnt3),   32'(((k - 1) / 3) % 16));
      chk($sformatf("wrap.done k%0d", k),  32'(done3),  32'((k % 3) == 0));
      @(negedge clk);
    end
    // Now at phase[1]: reset aborts the instruction
    #1;
    chk("wrap.pre_rst_phase", 32'(phase3), 32'h2);
    rst3 = 1;
    @(negedge clk); rst3 = 0;
    #1;
    chk("wrap.rst_phase",   32'(phase3),   0);
    chk("wrap.rst_cnt",     32'(cnt3),     0);
    chk("wrap.rst_running", 32'(running3), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/phase_sequencer.md
Name: phase_sequencer

Overview:
- Parametrised successor to the fixed 5-phase counter in the multi-cycle SIMPLE core.
- Generates a one-hot phase vector per instruction, with configurable phase count.
- Adds run, single-step and pause modes, a HLT-driven halt state, a memory-wait stall on a chosen phase, and a retired-instruction counter.
- Sits between the control unit and the phase-clocked datapath registers (IR, AR/BR, DR/SZCV, MDR/RF, PC).

Parameters:
- NPHASE, 5: phases per instruction; legal range 2..16.
- WAIT_PHASE, 1: phase index at which mem_wait can stall; must be < NPHASE-1.
- CNT_W, 32: width of the retired-instruction counter.
- WDOG_CYC, 255: stall-cycle limit, used only with the optional feature.

Ports:
- clk  in  1  system clock; everything is clocked on the rising edge.
- rst  in  1  synchronous reset, active high.
- run_req  in  1  one-cycle pulse: start continuous execution.
- step_req  in  1  one-cycle pulse: execute one instruction, or pause when running.
- halt_req  in  1  level from control: the current instruction is HLT; sampled at the last phase only.
- mem_wait  in  1  level: memory not ready; stalls in WAIT_PHASE.
- phase  out  NPHASE  one-hot active phase; all zero when not executing.
- ce  out  1  high in each cycle where the phase advances.
- running  out  1  state is RUN or STEP.
- halted  out  1  state is HALT.
- instr_done  out  1  high in the final-phase cycle in which the instruction completes.
- instr_cnt  out  CNT_W  number of retired instructions.
- wdog_err  out  1  sticky watchdog error; tied to 0 without the optional feature.

Behaviour:
- Clock and reset: one clock (clk); synchronous active-high reset rst.
- Reset values: state IDLE, phase_idx=0, pause_pend=0, phase=0, ce=0, running=0, halted=0, instr_done=0, instr_cnt=0, wdog_err=0.
- Reset mid-instruction aborts it with no completion and no count.
- States: IDLE, RUN, STEP, HALT.
- Phase output: phase = (1<<phase_idx) when running, else 0.
- stall = running & (phase_idx==WAIT_PHASE) & mem_wait.
- ce = running & ~stall.
- Advance: when ce=1 and phase_idx<NPHASE-1, phase_idx increments.
- Stall: phase_idx holds and ce=0 for as long as mem_wait stays high.
- Completion, ce=1 at phase_idx==NPHASE-1:
  - instr_done=1 for that cycle (combinational).
  - instr_cnt increments at that edge, wrapping modulo 2^CNT_W.
  - phase_idx returns to 0.
- Next state at completion, priority order:
  - halt_req=1 -> HALT.
  - else state STEP or pause_pend=1 -> IDLE; pause_pend cleared.
  - else remain RUN.
- IDLE:
  - run_req -> RUN.
  - else step_req -> STEP.
  - run_req and step_req in the same cycle -> RUN.
  - The first phase (phase[0]) appears in the cycle after the request; latency 1.
- RUN: step_req sets pause_pend. The instruction always finishes; it is never truncated. run_req is ignored.
- STEP: run_req and step_req are ignored.
- HALT: phase=0 and halted=1. All requests are ignored; only rst exits.
- halt_req is ignored outside the completion cycle.
- Back-to-back RUN instructions: phase[NPHASE-1] is followed directly by phase[0], with no idle gap.
- Cycles per instruction: NPHASE plus the number of stall cycles.

Optional Feature:
- Macro: PHASE_SEQ_WDOG_EN.
- Defined:
  - A stall counter counts consecutive stall cycles and clears on any non-stall cycle.
  - When the count reaches WDOG_CYC, the next edge sets wdog_err=1 (sticky) and forces HALT with no completion and no count.
  - rst clears wdog_err.
- Undefined: no stall counter; wdog_err is constant 0; mem_wait can stall indefinitely.

Test Plan:
- Defaults; rst, then run_req pulse, mem_wait=0 for 12 cycles -> phase sequence 00001,00010,00100,01000,10000,00001,...; instr_done high on cycles 5 and 10 after the request; instr_cnt=2.
- IDLE, step_req pulse -> exactly 5 one-hot phases, instr_done once, then phase=0, running=0, instr_cnt=1; step_req and run_req together -> continuous RUN.
- RUN, mem_wait high for 3 cycles starting at phase[1] -> phase[1] held 4 cycles, ce=0 for 3 cycles, instruction takes 8 cycles, count +1.
- RUN, step_req pulse during phase[2] -> the current instruction completes; then IDLE with no further phase[0]; halt_req=1 only at phase[4] -> HALT, halted=1; later run_req ignored.
- NPHASE=3, CNT_W=4, 16 instructions -> instr_cnt wraps 15->0; rst asserted at phase[1] -> next cycle IDLE, phase=0, instr_cnt=0.
- PHASE_SEQ_WDOG_EN, WDOG_CYC=4, mem_wait stuck high -> wdog_err=1 and HALT after 4 stall cycles, instr_cnt unchanged; without the macro the stall persists and wdog_err stays 0.
